// File: rtl/run_sequencer.sv
// run_sequencer: batch run controller for the 9-bit accumulator core.
// Starts NUM_PROGS programs back to back, times each run until Halt (or a
// cycle timeout) and reports one executed-cycle count per program.
module run_sequencer #(
   parameter int          NUM_PROGS      = 3,
   parameter int          START_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int          PW             = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          go,
   input  logic          Halt,
   output logic          start,
   output logic [PW-1:0] prog_sel,
   output logic          busy,
   output logic          cyc_valid,
   output logic [31:0]   cyc_count,
   output logic [PW-1:0] cyc_prog,
   output logic          timeout,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_RUN    = 3'd2,
      S_REPORT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [31:0]   START_LAST = 32'(START_CYCLES - 1);
   localparam logic [31:0]   RUN_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]   RUN_LIMIT  = 32'(TIMEOUT_CYCLES);
   localparam logic [PW-1:0] PROG_LAST  = PW'(NUM_PROGS - 1);

   state_t        state_reg;
   state_t        state_next;
   logic [31:0]   scnt_reg;        // cycles spent in START for this program
   logic [31:0]   rcnt_reg;        // RUN cycles elapsed for this program
   logic [31:0]   cyc_count_reg;
   logic [PW-1:0] prog_sel_reg;
   logic [PW-1:0] cyc_prog_reg;
   logic          timeout_reg;

   logic          start_last;
   logic          run_last;
   logic          batch_end;

   assign start_last = (scnt_reg == START_LAST);
   assign run_last   = (rcnt_reg == RUN_LAST);
   // A timed-out program aborts the rest of the batch.
   assign batch_end  = timeout_reg || (prog_sel_reg == PROG_LAST);

   // State register.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; Halt is only looked at in RUN so a stale Halt cannot end START early.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (go) state_next = S_START;
         S_START:  if (start_last) state_next = S_RUN;
         S_RUN:    if (Halt || run_last) state_next = S_REPORT;
         S_REPORT: state_next = batch_end ? S_DONE : S_START;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Counters, program index and latched report; Halt takes priority over the timeout.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         scnt_reg      <= '0;
         rcnt_reg      <= '0;
         cyc_count_reg <= '0;
         prog_sel_reg  <= '0;
         cyc_prog_reg  <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (go) begin
                  prog_sel_reg <= '0;
                  timeout_reg  <= 1'b0;
                  scnt_reg     <= '0;
               end
            end
            S_START: begin
               scnt_reg <= scnt_reg + 32'd1;
               rcnt_reg <= '0;
            end
            S_RUN: begin
               if (Halt) begin
                  cyc_count_reg <= rcnt_reg;
                  cyc_prog_reg  <= prog_sel_reg;
               end else if (run_last) begin
                  cyc_count_reg <= RUN_LIMIT;
                  cyc_prog_reg  <= prog_sel_reg;
                  timeout_reg   <= 1'b1;
               end else begin
                  rcnt_reg <= rcnt_reg + 32'd1;
               end
            end
            S_REPORT: begin
               if (!batch_end) begin
                  prog_sel_reg <= prog_sel_reg + 1'b1;
                  scnt_reg     <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Strobes and status decoded from the state register only.
   always_comb begin
      start     = (state_reg == S_START);
      busy      = (state_reg != S_IDLE);
      cyc_valid = (state_reg == S_REPORT);
      done      = (state_reg == S_DONE);
   end

   assign prog_sel  = prog_sel_reg;
   assign cyc_count = cyc_count_reg;
   assign cyc_prog  = cyc_prog_reg;
   assign timeout   = timeout_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed bench for run_sequencer (3-program batch with a
// 20-cycle timeout, plus a single-program instance with the default timeout).
module tb_run_sequencer;

   localparam int TO = 20;

   logic        CLK;
   logic        reset;

   // three-program instance
   logic        go;
   logic        halt;
   logic        start;
   logic [1:0]  prog_sel;
   logic        busy;
   logic        cyc_valid;
   logic [31:0] cyc_count;
   logic [1:0]  cyc_prog;
   logic        timeout;
   logic        done;

   // single-program instance
   logic        s_go;
   logic        s_halt;
   logic        s_start;
   logic [0:0]  s_prog_sel;
   logic        s_busy;
   logic        s_valid;
   logic [31:0] s_count;
   logic [0:0]  s_prog;
   logic        s_timeout;
   logic        s_done;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_done  = 0;
   int base_valid;
   int base_done;

   run_sequencer #(
      .NUM_PROGS(3),
      .START_CYCLES(2),
      .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .CLK(CLK),
      .reset(reset),
      .go(go),
      .Halt(halt),
      .start(start),
      .prog_sel(prog_sel),
      .busy(busy),
      .cyc_valid(cyc_valid),
      .cyc_count(cyc_count),
      .cyc_prog(cyc_prog),
      .timeout(timeout),
      .done(done)
   );

   run_sequencer #(
      .NUM_PROGS(1),
      .START_CYCLES(2)
   ) u_single (
      .CLK(CLK),
      .reset(reset),
      .go(s_go),
      .Halt(s_halt),
      .start(s_start),
      .prog_sel(s_prog_sel),
      .busy(s_busy),
      .cyc_valid(s_valid),
      .cyc_count(s_count),
      .cyc_prog(s_prog),
      .timeout(s_timeout),
      .done(s_done)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // count report and done strobes of the three-program instance
   always @(negedge CLK) begin
      if (cyc_valid) n_valid++;
      if (done) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // From IDLE: raise go for one edge; returns in the first START cycle.
   task automatic begin_batch();
      check("idle_start", 32'(start), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      go = 1'b1;
      tick();
   endtask

   // Runs one program starting in its first START cycle. k = RUN cycle on
   // which Halt rises; sh = Halt level held during START; to = never halt.
   // Returns in the cycle after REPORT.
   task automatic do_prog(input int p, input int k, input bit sh, input bit to);
      int exp_cnt;
      exp_cnt = to ? TO : k;
      check("s0_start", 32'(start), 32'd1);
      check("s0_busy", 32'(busy), 32'd1);
      check("s0_psel", 32'(prog_sel), 32'(p));
      halt = sh;
      tick();
      check("s1_start", 32'(start), 32'd1);
      check("s1_psel", 32'(prog_sel), 32'(p));
      tick();
      check("run_start", 32'(start), 32'd0);
      check("run_valid", 32'(cyc_valid), 32'd0);
      halt = 1'b0;
      if (to) begin
         repeat (TO) tick();
      end else begin
         repeat (k) tick();
         halt = 1'b1;
         tick();
      end
      check("rep_valid", 32'(cyc_valid), 32'd1);
      check("rep_count", cyc_count, 32'(exp_cnt));
      check("rep_prog", 32'(cyc_prog), 32'(p));
      check("rep_timeout", 32'(timeout), 32'(to));
      check("rep_start", 32'(start), 32'd0);
      $display("[TB] prog %0d report count=%0d timeout=%0d", cyc_prog, cyc_count, timeout);
      halt = 1'b0;
      tick();
      check("post_valid", 32'(cyc_valid), 32'd0);
      check("post_count_hold", cyc_count, 32'(exp_cnt));
   endtask

   initial begin
      reset  = 1'b1;
      go     = 1'b0;
      halt   = 1'b0;
      s_go   = 1'b0;
      s_halt = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // reset state
      check("rst_start", 32'(start), 32'd0);
      check("rst_psel", 32'(prog_sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(cyc_valid), 32'd0);
      check("rst_count", cyc_count, 32'd0);
      check("rst_prog", 32'(cyc_prog), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_done", 32'(done), 32'd0);

      // batch A: halts after 5/0/7, go held high while busy, stale Halt in START
      base_valid = n_valid;
      base_done  = n_done;
      begin_batch();
      do_prog(0, 5, 1'b0, 1'b0);
      do_prog(1, 0, 1'b1, 1'b0);
      go = 1'b0;
      do_prog(2, 7, 1'b1, 1'b0);
      check("a_done", 32'(done), 32'd1);
      check("a_done_busy", 32'(busy), 32'd1);
      check("a_done_start", 32'(start), 32'd0);
      check("a_done_psel", 32'(prog_sel), 32'd2);
      $display("[TB] batch A done");
      tick();
      check("a_idle_done", 32'(done), 32'd0);
      check("a_idle_busy", 32'(busy), 32'd0);
      check("a_idle_psel", 32'(prog_sel), 32'd2);
      check("a_nvalid", 32'(n_valid - base_valid), 32'd3);
      check("a_ndone", 32'(n_done - base_done), 32'd1);

      // batch B: Halt together with the limit, then a timeout on program 1
      base_valid = n_valid;
      base_done  = n_done;
      begin_batch();
      go = 1'b0;
      check("b_psel_reset", 32'(prog_sel), 32'd0);
      do_prog(0, TO - 1, 1'b0, 1'b0);
      do_prog(1, 0, 1'b0, 1'b1);
      check("b_done", 32'(done), 32'd1);
      check("b_done_timeout", 32'(timeout), 32'd1);
      check("b_done_psel", 32'(prog_sel), 32'd1);
      $display("[TB] batch B done (timeout)");
      tick();
      check("b_idle_busy", 32'(busy), 32'd0);
      check("b_idle_timeout", 32'(timeout), 32'd1);
      repeat (3) tick();
      check("b_no_prog2", 32'(start), 32'd0);
      check("b_idle_psel", 32'(prog_sel), 32'd1);
      check("b_nvalid", 32'(n_valid - base_valid), 32'd2);
      check("b_ndone", 32'(n_done - base_done), 32'd1);

      // batch C: next go clears timeout; asynchronous reset mid-RUN of program 1
      base_valid = n_valid;
      base_done  = n_done;
      begin_batch();
      go = 1'b0;
      check("c_timeout_clr", 32'(timeout), 32'd0);
      do_prog(0, 3, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      tick();
      check("c_run_busy", 32'(busy), 32'd1);
      check("c_run_psel", 32'(prog_sel), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("c_arst_busy", 32'(busy), 32'd0);
      check("c_arst_start", 32'(start), 32'd0);
      check("c_arst_psel", 32'(prog_sel), 32'd0);
      check("c_arst_count", cyc_count, 32'd0);
      check("c_arst_prog", 32'(cyc_prog), 32'd0);
      check("c_arst_valid", 32'(cyc_valid), 32'd0);
      check("c_arst_done", 32'(done), 32'd0);
      $display("[TB] batch C reset mid-run");
      tick();
      reset = 1'b0;
      halt  = 1'b1;
      repeat (3) tick();
      halt = 1'b0;
      check("c_post_busy", 32'(busy), 32'd0);
      check("c_nvalid", 32'(n_valid - base_valid), 32'd1);
      check("c_ndone", 32'(n_done - base_done), 32'd0);

      // single-program instance: Halt held from the 10th RUN cycle
      check("s_pre_start", 32'(s_start), 32'd0);
      s_go = 1'b1;
      tick();
      s_go = 1'b0;
      check("s_c1_start", 32'(s_start), 32'd1);
      tick();
      check("s_c2_start", 32'(s_start), 32'd1);
      tick();
      check("s_run_start", 32'(s_start), 32'd0);
      repeat (9) tick();
      s_halt = 1'b1;
      tick();
      check("s_rep_valid", 32'(s_valid), 32'd1);
      check("s_rep_count", s_count, 32'd9);
      check("s_rep_prog", 32'(s_prog), 32'd0);
      $display("[TB] single prog report count=%0d", s_count);
      tick();
      check("s_done", 32'(s_done), 32'd1);
      check("s_done_valid", 32'(s_valid), 32'd0);
      check("s_timeout", 32'(s_timeout), 32'd0);
      tick();
      s_halt = 1'b0;
      check("s_idle_done", 32'(s_done), 32'd0);
      check("s_idle_busy", 32'(s_busy), 32'd0);
      check("s_idle_start", 32'(s_start), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
